// File: rtl/fft_bitrev_loader.sv
// fft_bitrev_loader: writes a frame of complex samples to RAM at bit-reversed addresses, then hands off to the FFT engine.
module fft_bitrev_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [9:0]               N,
    input  logic [3:0]               M,
    input  logic                     inv,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  logic                     fft_complete,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic signed [DATA_W-1:0] wr_re,
    output logic signed [DATA_W-1:0] wr_im,
    output logic                     resort_complete,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE, WAIT_FFT} state_t;
    localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    state_t                     state_q;
    logic [9:0]                 cnt_q, n_q;
    logic [3:0]                 m_q;
    logic                       inv_q;
    logic                       wr_en_q, resort_q, busy_q;
    logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d, idx, rev;
    logic signed [DATA_W-1:0]   wr_re_q, wr_im_q, wr_im_d;
    logic                       idle, legal, hs, inv_eff;
    logic [3:0]                 m_eff;
    assign idle     = state_q == IDLE;
    assign in_ready = idle || state_q == LOAD;
    assign hs       = in_valid && in_ready;
    assign legal    = M != 4'd0 && M <= 4'(ADDR_W) && N == (10'd1 << M);
    // The first sample of a frame uses the live configuration it is about to latch.
    assign m_eff    = idle ? (legal ? M : 4'd1) : m_q;
    assign inv_eff  = idle ? inv : inv_q;
    assign idx      = idle ? '0 : ADDR_W'(cnt_q);
    always_comb begin
        rev = '0;
        for (int i = 0; i < ADDR_W; i++) rev[i] = idx[ADDR_W-1-i];
    end
    assign wr_addr_d = rev >> (4'(ADDR_W) - m_eff);
    assign wr_im_d   = !inv_eff ? in_im : (in_im == S_MIN ? S_MAX : -in_im);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            n_q       <= '0;
            m_q       <= '0;
            inv_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_re_q   <= '0;
            wr_im_q   <= '0;
            resort_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            wr_en_q   <= hs;
            wr_addr_q <= hs ? wr_addr_d : '0;
            wr_re_q   <= hs ? in_re : '0;
            wr_im_q   <= hs ? wr_im_d : '0;
            // One cycle behind DONE so the last write has landed before the engine starts.
            resort_q  <= state_q == DONE;
            case (state_q)
                IDLE: if (hs) begin
                    m_q     <= legal ? M : 4'd1;
                    n_q     <= legal ? N : 10'd2;
                    inv_q   <= inv;
                    cnt_q   <= 10'd1;
                    busy_q  <= 1'b1;
                    state_q <= LOAD;
                end
                LOAD: if (hs) begin
                    cnt_q   <= cnt_q + 10'd1;
                    state_q <= cnt_q == n_q - 10'd1 ? DONE : LOAD;
                end
                DONE: state_q <= WAIT_FFT;
                WAIT_FFT: if (fft_complete) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign wr_en           = wr_en_q;
    assign wr_addr         = wr_addr_q;
    assign wr_re           = wr_re_q;
    assign wr_im           = wr_im_q;
    assign resort_complete = resort_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_fft_bitrev_loader.sv
// tb_fft_bitrev_loader: directed frames with a write scoreboard for fft_bitrev_loader.
module tb_fft_bitrev_loader;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [9:0]         N = '0;
    logic [3:0]         M = '0;
    logic               inv = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_re = '0;
    logic signed [15:0] in_im = '0;
    logic               fft_complete = 1'b0;
    logic               wr_en;
    logic [8:0]         wr_addr;
    logic signed [15:0] wr_re, wr_im;
    logic               resort_complete, busy;
    int                 checks = 0;
    int                 failures = 0;
    int                 rc_total = 0;
    logic               rc_prev = 1'b0;
    logic [40:0]        exp_q[$];

    fft_bitrev_loader #(.DATA_W(16), .ADDR_W(9)) dut (
        .clk(clk), .rst(rst), .N(N), .M(M), .inv(inv),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .fft_complete(fft_complete), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_re(wr_re), .wr_im(wr_im), .resort_complete(resort_complete), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] brev(input int i, input int m);
        logic [8:0] a;
        a = '0;
        for (int b = 0; b < m; b++) a[b] = i[m-1-b];
        return a;
    endfunction

    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) chk("unexpected_write", 64'(exp_q.size() > 0), 64'd1);
            else chk("write", {wr_addr, wr_re, wr_im}, exp_q.pop_front());
        end else chk("idle_bus", {wr_addr, wr_re, wr_im}, 64'd0);
        if (resort_complete) begin
            rc_total++;
            chk("rc_double", rc_prev, 64'd0);
        end
        rc_prev = resort_complete;
    end

    task automatic frame(input int m_in, input int n_in, input logic inv_in, input int m_eff,
                         input int n_send, input bit gaps, input bit full, input int base);
        logic signed [15:0] re, im, ei;
        M = 4'(m_in); N = 10'(n_in); inv = inv_in;
        for (int i = 0; i < n_send; i++) begin
            re = 16'(base + i);
            im = (i % 4 == 1) ? 16'sh8000 : 16'(100 + 50 * i);
            ei = !inv_in ? im : (im == 16'sh8000 ? 16'sh7fff : -im);
            chk("in_ready_load", in_ready, 64'd1);
            in_valid = 1'b1; in_re = re; in_im = im;
            exp_q.push_back({brev(i, m_eff), re, ei});
            @(negedge clk);
            if (i == 0) begin M = 4'd2; N = 10'd4; inv = ~inv_in; end
            in_valid = 1'b0;
            if (gaps && i != n_send - 1) @(negedge clk);
        end
        if (full) begin
            chk("rc_t1", resort_complete, 64'd0);
            @(negedge clk);
            chk("rc_t2", resort_complete, 64'd1);
            @(negedge clk);
            chk("rc_t3", resort_complete, 64'd0);
            chk("ready_wait", in_ready, 64'd0);
            chk("busy_wait", busy, 64'd1);
        end
    endtask

    task automatic fft_pulse();
        fft_complete = 1'b1;
        @(negedge clk);
        fft_complete = 1'b0;
        chk("ready_after_fft", in_ready, 64'd1);
        chk("busy_after_fft", busy, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", in_ready, 64'd1);
        chk("rst_wr_en", wr_en, 64'd0);
        chk("rst_bus", {wr_addr, wr_re, wr_im}, 64'd0);
        chk("rst_rc", resort_complete, 64'd0);
        chk("rst_busy", busy, 64'd0);
        repeat (2) @(negedge clk);
        // bit reversal over 3 bits
        frame(3, 8, 1'b0, 3, 8, 1'b0, 1'b1, 0);
        // held input while blocked must not be consumed
        in_valid = 1'b1; in_re = 16'sh7777; in_im = 16'sh1234;
        repeat (20) @(negedge clk);
        chk("blocked_ready", in_ready, 64'd0);
        chk("blocked_busy", busy, 64'd1);
        fft_pulse();
        in_valid = 1'b0;
        // conjugation with saturation
        frame(1, 2, 1'b1, 1, 2, 1'b0, 1'b1, -7);
        fft_pulse();
        // full 512-point frame with input gaps
        frame(9, 512, 1'b0, 9, 512, 1'b1, 1'b1, 1000);
        fft_pulse();
        // reset mid-frame, coinciding with a handshake
        frame(3, 8, 1'b0, 3, 5, 1'b0, 1'b0, 200);
        in_valid = 1'b1; in_re = 16'sh0555; in_im = 16'sh0666; rst = 1'b1;
        @(negedge clk);
        chk("midrst_wr_en", wr_en, 64'd0);
        chk("midrst_bus", {wr_addr, wr_re, wr_im}, 64'd0);
        chk("midrst_rc", resort_complete, 64'd0);
        chk("midrst_busy", busy, 64'd0);
        chk("midrst_ready", in_ready, 64'd1);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        frame(3, 8, 1'b1, 3, 8, 1'b0, 1'b1, 300);
        fft_pulse();
        // illegal configuration falls back to M=1, N=2
        frame(0, 2, 1'b0, 1, 2, 1'b0, 1'b1, 400);
        fft_pulse();
        repeat (5) @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 64'd0);
        chk("rc_total", rc_total, 64'd5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
